// File: rtl/axi_pattern_pkg.sv
// axi_pattern_pkg: shared FSM states, AXI response codes and the write/read data pattern seed
package axi_pattern_pkg;
  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, FIN} state_t;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [31:0] PATTERN_SEED = 32'h0000_0100;
endpackage

// File: rtl/axi_pattern_master.sv
// axi_pattern_master: AXI4 master writing C_NUM_BURSTS INCR bursts of seed+k, reading them back and flagging ERROR, DONE when finished
module axi_pattern_master
  import axi_pattern_pkg::*;
#(
  parameter logic [31:0] C_BASE_ADDR = 32'h4000_0000,
  parameter int C_BURST_LEN = 16,
  parameter int C_NUM_BURSTS = 4
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  output logic        ERROR,
  output logic        DONE,
  output logic [31:0] M_AXI_AWADDR,
  output logic [7:0]  M_AXI_AWLEN,
  output logic [2:0]  M_AXI_AWSIZE,
  output logic [1:0]  M_AXI_AWBURST,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_WLAST,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic [1:0]  M_AXI_BRESP,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY,
  output logic [31:0] M_AXI_ARADDR,
  output logic [7:0]  M_AXI_ARLEN,
  output logic [2:0]  M_AXI_ARSIZE,
  output logic [1:0]  M_AXI_ARBURST,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  input  logic [31:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RLAST,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY
);
  localparam int BW = C_BURST_LEN > 1 ? $clog2(C_BURST_LEN) : 1;
  localparam int NW = C_NUM_BURSTS > 1 ? $clog2(C_NUM_BURSTS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(C_BURST_LEN - 1);
  localparam logic [NW-1:0] LAST_BURST = NW'(C_NUM_BURSTS - 1);
  localparam logic [31:0] STEP = 32'(C_BURST_LEN * 4);
  state_t state;
  logic [BW-1:0] beat;
  logic [NW-1:0] burst;
  logic [31:0] addr, pat;
  logic last_beat, r_bad;
  assign last_beat = beat == LAST_BEAT;
  assign r_bad = M_AXI_RRESP != RESP_OKAY || M_AXI_RDATA != pat || M_AXI_RLAST != last_beat;
  assign M_AXI_AWADDR = addr;
  assign M_AXI_ARADDR = addr;
  assign M_AXI_WDATA = pat;
  assign M_AXI_AWLEN = 8'(C_BURST_LEN - 1);
  assign M_AXI_ARLEN = 8'(C_BURST_LEN - 1);
  assign M_AXI_AWSIZE = 3'b010;
  assign M_AXI_ARSIZE = 3'b010;
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_WSTRB = 4'hF;
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state <= IDLE;
      beat <= '0;
      burst <= '0;
      addr <= C_BASE_ADDR;
      pat <= PATTERN_SEED;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID <= 1'b0;
      M_AXI_WLAST <= 1'b0;
      M_AXI_BREADY <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY <= 1'b0;
      ERROR <= 1'b0;
      DONE <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          M_AXI_AWVALID <= 1'b1;
          state <= WR_ADDR;
        end
        WR_ADDR: if (M_AXI_AWREADY) begin
          M_AXI_AWVALID <= 1'b0;
          M_AXI_WVALID <= 1'b1;
          M_AXI_WLAST <= C_BURST_LEN == 1;
          state <= WR_DATA;
        end
        WR_DATA: if (M_AXI_WREADY) begin
          pat <= pat + 32'd1;
          if (M_AXI_WLAST) begin
            M_AXI_WVALID <= 1'b0;
            M_AXI_WLAST <= 1'b0;
            M_AXI_BREADY <= 1'b1;
            beat <= '0;
            state <= WR_RESP;
          end else begin
            beat <= beat + 1'b1;
            M_AXI_WLAST <= beat + 1'b1 == LAST_BEAT;
          end
        end
        WR_RESP: if (M_AXI_BVALID) begin
          M_AXI_BREADY <= 1'b0;
          if (M_AXI_BRESP != RESP_OKAY) ERROR <= 1'b1;
          if (burst == LAST_BURST) begin
            burst <= '0;
            addr <= C_BASE_ADDR;
            pat <= PATTERN_SEED;
            M_AXI_ARVALID <= 1'b1;
            state <= RD_ADDR;
          end else begin
            burst <= burst + 1'b1;
            addr <= addr + STEP;
            M_AXI_AWVALID <= 1'b1;
            state <= WR_ADDR;
          end
        end
        RD_ADDR: if (M_AXI_ARREADY) begin
          M_AXI_ARVALID <= 1'b0;
          M_AXI_RREADY <= 1'b1;
          state <= RD_DATA;
        end
        RD_DATA: if (M_AXI_RVALID) begin
          pat <= pat + 32'd1;
          if (r_bad) ERROR <= 1'b1;
          if (last_beat) begin
            beat <= '0;
            M_AXI_RREADY <= 1'b0;
            if (burst == LAST_BURST) begin
              DONE <= 1'b1;
              state <= FIN;
            end else begin
              burst <= burst + 1'b1;
              addr <= addr + STEP;
              M_AXI_ARVALID <= 1'b1;
              state <= RD_ADDR;
            end
          end else beat <= beat + 1'b1;
        end
        default: state <= FIN;
      endcase
    end
  end
endmodule
